matmul_sp_stream: RTL

- Parametrised scratchpad for the matmul datapath with SP_NTARGETS independent result slots.
- Each slot holds one MAX_DIM x MAX_DIM matrix of BUS_WIDTH-bit elements.
- Elements are written one at a time, either overwrite or accumulate, with a sticky per-slot overflow flag.
- A slot can be streamed out row-major over a valid/ready bus with a last marker. It sits between the PE array write-back and the bus read-out logic.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/matmul_sp_slot.sv | 66 ++++++
 rtl/matmul_sp_stream.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result scratchpad.
// Holds the default configuration, derived index widths, the element type,
// the read-out FSM state encoding and a small width helper.
package matmul_pkg;

  localparam int SP_DEF_DATA_WIDTH = 16;
  localparam int SP_DEF_BUS_WIDTH  = 64;
  localparam int SP_DEF_NTARGETS   = 4;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int sp_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SP_MAX_DIM = SP_DEF_BUS_WIDTH / SP_DEF_DATA_WIDTH;
  localparam int SP_IDX_W   = sp_clog2_min1(SP_DEF_NTARGETS);
  localparam int SP_DIM_W   = sp_clog2_min1(SP_MAX_DIM);

  typedef logic [SP_DEF_BUS_WIDTH-1:0] sp_elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LAST   = 2'd2
  } stream_state_e;

endpackage

// File: rtl/matmul_sp_slot.sv
// Single scratchpad slot: a MAX_DIM x MAX_DIM matrix of BUS_WIDTH-bit elements.
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   wr_en_i, wr_acc_i      element write strobe; 1 = accumulate, 0 = overwrite
//   wr_row_i, wr_col_i     element coordinates for the write
//   wr_data_i              element value / addend
//   clr_i                  zero every element and the overflow flag (wins over write)
//   rd_row_i, rd_col_i     asynchronous read coordinates
//   rd_data_o              element at (rd_row_i, rd_col_i)
//   ovf_o                  sticky carry-out flag from accumulates
module matmul_sp_slot
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH = SP_DEF_BUS_WIDTH,
  parameter int MAX_DIM   = SP_MAX_DIM,
  parameter int DIM_W     = SP_DIM_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic                 wr_acc_i,
  input  logic [DIM_W-1:0]     wr_row_i,
  input  logic [DIM_W-1:0]     wr_col_i,
  input  logic [BUS_WIDTH-1:0] wr_data_i,
  input  logic                 clr_i,
  input  logic [DIM_W-1:0]     rd_row_i,
  input  logic [DIM_W-1:0]     rd_col_i,
  output logic [BUS_WIDTH-1:0] rd_data_o,
  output logic                 ovf_o
);

  logic [BUS_WIDTH-1:0] mem_q [MAX_DIM][MAX_DIM];
  logic [BUS_WIDTH:0]   acc_sum;

  // One extra bit so the carry out of the MSB is visible.
  assign acc_sum   = {1'b0, mem_q[wr_row_i][wr_col_i]} + {1'b0, wr_data_i};
  assign rd_data_o = mem_q[rd_row_i][rd_col_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          mem_q[r][c] <= '0;
        end
      end
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          mem_q[r][c] <= '0;
        end
      end
      ovf_o <= 1'b0;
    end else if (wr_en_i) begin
      if (wr_acc_i) begin
        mem_q[wr_row_i][wr_col_i] <= acc_sum[BUS_WIDTH-1:0];
        if (acc_sum[BUS_WIDTH]) begin
          ovf_o <= 1'b1;
        end
      end else begin
        mem_q[wr_row_i][wr_col_i] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/matmul_sp_stream.sv
// Multi-slot result scratchpad with a row-major valid/ready read-out stream.
// Sits between the PE array write-back and the bus read-out logic.
//
//   state  | meaning
//   IDLE   | no stream; rd_start_i accepted, out_valid_o = 0
//   STREAM | presenting a non-final element, advance on each accepted beat
//   LAST   | presenting the final element with out_last_o = 1
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   wr_en_i/wr_acc_i/wr_target_i/wr_row_i/wr_col_i/wr_data_i   element write
//   wr_err_o                     one-cycle pulse: write/clear hit the streaming slot
//   clr_en_i/clr_target_i        clear one slot and its overflow flag
//   rd_start_i/rd_target_i/rd_nrows_i/rd_ncols_i   start a stream (dims minus 1)
//   out_valid_o/out_ready_i/out_data_o/out_last_o  output stream
//   busy_o                       stream in progress
//   ovf_o                        sticky per-slot accumulate overflow flags
module matmul_sp_stream
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = SP_DEF_DATA_WIDTH,
  parameter int BUS_WIDTH   = SP_DEF_BUS_WIDTH,
  parameter int SP_NTARGETS = SP_DEF_NTARGETS,
  parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int IDX_W      = sp_clog2_min1(SP_NTARGETS),
  localparam int DIM_W      = sp_clog2_min1(MAX_DIM)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic                   wr_acc_i,
  input  logic [IDX_W-1:0]       wr_target_i,
  input  logic [DIM_W-1:0]       wr_row_i,
  input  logic [DIM_W-1:0]       wr_col_i,
  input  logic [BUS_WIDTH-1:0]   wr_data_i,
  output logic                   wr_err_o,
  input  logic                   clr_en_i,
  input  logic [IDX_W-1:0]       clr_target_i,
  input  logic                   rd_start_i,
  input  logic [IDX_W-1:0]       rd_target_i,
  input  logic [DIM_W-1:0]       rd_nrows_i,
  input  logic [DIM_W-1:0]       rd_ncols_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BUS_WIDTH-1:0]   out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic [SP_NTARGETS-1:0] ovf_o
);

  stream_state_e state_q, state_d;

  logic [IDX_W-1:0]     tgt_q;
  logic [DIM_W-1:0]     row_q, col_q, nrows_q, ncols_q;
  logic [DIM_W-1:0]     seq_row, seq_col;
  logic                 load, advance;
  logic                 busy;
  logic                 err_now;
  logic [IDX_W-1:0]     rd_sel;
  logic [DIM_W-1:0]     rd_row, rd_col;
  logic [BUS_WIDTH-1:0] slot_data [SP_NTARGETS];
  logic [BUS_WIDTH-1:0] rd_elem;

  assign busy        = (state_q != IDLE);
  assign busy_o      = busy;
  assign out_valid_o = busy;
  assign out_last_o  = (state_q == LAST);

  // Coordinates of the element following the one currently presented.
  always_comb begin
    seq_row = row_q;
    seq_col = col_q + DIM_W'(1);
    if (col_q == ncols_q) begin
      seq_col = '0;
      seq_row = row_q + DIM_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start_i) begin
          load    = 1'b1;
          state_d = (rd_nrows_i == '0 && rd_ncols_i == '0) ? LAST : STREAM;
        end
      end
      STREAM: begin
        if (out_ready_i) begin
          advance = 1'b1;
          if (seq_row == nrows_q && seq_col == ncols_q) begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The output register is loaded from the read mux one cycle ahead of use:
  // element (0,0) of the requested slot when starting, otherwise the next
  // element in row-major order of the latched slot.
  always_comb begin
    rd_sel = tgt_q;
    rd_row = seq_row;
    rd_col = seq_col;
    if (state_q == IDLE) begin
      rd_sel = rd_target_i;
      rd_row = '0;
      rd_col = '0;
    end
  end

  assign rd_elem = slot_data[rd_sel];

  // The streaming slot is frozen; anything aimed at it is dropped and flagged.
  assign err_now = busy && ((wr_en_i  && wr_target_i  == tgt_q) ||
                            (clr_en_i && clr_target_i == tgt_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      nrows_q    <= '0;
      ncols_q    <= '0;
      out_data_o <= '0;
      wr_err_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_err_o <= err_now;
      if (load) begin
        tgt_q      <= rd_target_i;
        nrows_q    <= rd_nrows_i;
        ncols_q    <= rd_ncols_i;
        row_q      <= '0;
        col_q      <= '0;
        out_data_o <= rd_elem;
      end else if (advance) begin
        row_q      <= seq_row;
        col_q      <= seq_col;
        out_data_o <= rd_elem;
      end
    end
  end

  for (genvar s = 0; s < SP_NTARGETS; s++) begin : g_slot
    logic locked;
    logic slot_wr;
    logic slot_clr;

    assign locked   = busy && (tgt_q == IDX_W'(s));
    assign slot_wr  = wr_en_i  && (wr_target_i  == IDX_W'(s)) && !locked;
    assign slot_clr = clr_en_i && (clr_target_i == IDX_W'(s)) && !locked;

    matmul_sp_slot #(
      .BUS_WIDTH (BUS_WIDTH),
      .MAX_DIM   (MAX_DIM),
      .DIM_W     (DIM_W)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (slot_wr),
      .wr_acc_i  (wr_acc_i),
      .wr_row_i  (wr_row_i),
      .wr_col_i  (wr_col_i),
      .wr_data_i (wr_data_i),
      .clr_i     (slot_clr),
      .rd_row_i  (rd_row),
      .rd_col_i  (rd_col),
      .rd_data_o (slot_data[s]),
      .ovf_o     (ovf_o[s])
    );
  end

endmodule
